// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and the write-request payload for regfile_mp.
// Optional macro REGFILE_BYPASS_EN (used by regfile_mp) enables same-cycle write forwarding.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned NUM_REGS_DEF = 32;
  localparam int unsigned ZERO_REG     = 0;

  // Write-request widths for the default geometry.
  localparam int unsigned WREQ_AW = $clog2(NUM_REGS_DEF);
  localparam int unsigned WREQ_DW = DATA_W_DEF;

  typedef struct packed {
    logic               en;
    logic [WREQ_AW-1:0] addr;
    logic [WREQ_DW-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending-write flags for RAW hazard detection.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   claim_en_i, claim_addr_i     decode claims a destination register
//   wr_en0_i/wr_addr0_i          write port 0 (clears the flag)
//   wr_en1_i/wr_addr1_i          write port 1 (clears the flag)
//   busy_o                       registered busy vector, bit 0 always 0
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int unsigned NUM_REGS = NUM_REGS_DEF,
  localparam int unsigned AW       = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                claim_en_i,
  input  logic [AW-1:0]       claim_addr_i,
  input  logic                wr_en0_i,
  input  logic [AW-1:0]       wr_addr0_i,
  input  logic                wr_en1_i,
  input  logic [AW-1:0]       wr_addr1_i,
  output logic [NUM_REGS-1:0] busy_o
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Writes clear first; a same-cycle claim then re-sets, since the newer producer owns the register.
  always_comb begin
    busy_d = busy_q;
    if (wr_en0_i) busy_d[wr_addr0_i] = 1'b0;
    if (wr_en1_i) busy_d[wr_addr1_i] = 1'b0;
    if (claim_en_i && (claim_addr_i != AW'(ZERO_REG))) busy_d[claim_addr_i] = 1'b1;
    busy_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file, NUM_RD combinational reads, two synchronous
// write ports (port 1 wins on conflict), r0 hardwired to zero, pending-write scoreboard.
// Macro REGFILE_BYPASS_EN: forward same-cycle writes to the read ports.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   rd_addr / rd_data / rd_busy       packed read ports, port k at [k*W +: W]
//   wr_en0/wr_addr0/wr_data0          write port 0
//   wr_en1/wr_addr1/wr_data1          write port 1
//   claim_en/claim_addr               destination claim from decode
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int unsigned DATA_W   = DATA_W_DEF,
  parameter  int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter  int unsigned NUM_RD   = 2,
  localparam int unsigned AW       = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en0,
  input  logic [AW-1:0]            wr_addr0,
  input  logic [DATA_W-1:0]        wr_data0,
  input  logic                     wr_en1,
  input  logic [AW-1:0]            wr_addr1,
  input  logic [DATA_W-1:0]        wr_data1,
  input  logic                     claim_en,
  input  logic [AW-1:0]            claim_addr
);

  typedef struct packed {
    logic              en;
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] data;
  } wr_port_t;

  wr_port_t            wr_c [2];
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_vec;
  logic [AW-1:0]       ra_c;
  logic [DATA_W-1:0]   rdat_c;
  logic                rbusy_c;

  // Index 1 is applied last so port 1 wins a same-address conflict.
  always_comb begin
    wr_c[0].en   = wr_en0;
    wr_c[0].addr = wr_addr0;
    wr_c[0].data = wr_data0;
    wr_c[1].en   = wr_en1;
    wr_c[1].addr = wr_addr1;
    wr_c[1].data = wr_data1;
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .claim_en_i   (claim_en),
    .claim_addr_i (claim_addr),
    .wr_en0_i     (wr_en0),
    .wr_addr0_i   (wr_addr0),
    .wr_en1_i     (wr_en1),
    .wr_addr1_i   (wr_addr1),
    .busy_o       (busy_vec)
  );

  // Storage next-state; writes to r0 are dropped.
  always_comb begin
    regs_d = regs_q;
    for (int p = 0; p < 2; p++) begin
      if (wr_c[p].en && (wr_c[p].addr != AW'(ZERO_REG))) regs_d[wr_c[p].addr] = wr_c[p].data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read muxes; r0 forced last so it overrides any forwarding.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra_c    = '0;
    rdat_c  = '0;
    rbusy_c = 1'b0;
    for (int k = 0; k < int'(NUM_RD); k++) begin
      ra_c    = rd_addr[k*AW +: AW];
      rdat_c  = regs_q[ra_c];
      rbusy_c = busy_vec[ra_c];
`ifdef REGFILE_BYPASS_EN
      for (int p = 0; p < 2; p++) begin
        if (wr_c[p].en && (wr_c[p].addr == ra_c)) begin
          rdat_c  = wr_c[p].data;
          rbusy_c = claim_en && (claim_addr == ra_c);
        end
      end
`endif
      if (ra_c == AW'(ZERO_REG)) begin
        rdat_c  = '0;
        rbusy_c = 1'b0;
      end
      rd_data[k*DATA_W +: DATA_W] = rdat_c;
      rd_busy[k]                  = rbusy_c;
    end
  end

endmodule
